// File: rtl/cilantro_ifetch.sv
// Instruction fetch stage for the cilantro core: owns the PC, issues word
// fetches with credit flow control and buffers returned words with their PC.
module cilantro_ifetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    localparam int         OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          imem_req_valid,
    output logic [31:0]   imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          instr_valid,
    output logic [31:0]   instr_data,
    output logic [31:0]   instr_pc,
    input  logic          instr_ready,
    output logic [OW-1:0] outstanding
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [OW-1:0] ost_q, ost_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [31:0]   fpc_q [FIFO_DEPTH];
    logic [31:0]   fdat_q [FIFO_DEPTH];

    logic credit;
    logic accept;
    logic rsp_ok;
    logic push;
    logic pop;

    always_comb begin
        credit = (int'(ost_q) < MAX_OUTSTANDING)
              && (int'(ost_q) + int'(cnt_q) < FIFO_DEPTH);
        imem_req_valid = !rst && !redirect_valid && credit;
        accept = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error; ignore it.
        rsp_ok = imem_rsp_valid && (ost_q != '0);
        push   = rsp_ok && (drop_q == '0) && !redirect_valid;
        pop    = (cnt_q != '0) && instr_ready && !redirect_valid;

        ost_d  = ost_q + OW'(accept) - OW'(rsp_ok);
        drop_d = drop_q;
        pc_d   = pc_q;
        rpc_d  = rpc_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        wp_d   = wp_q + PW'(push);
        rp_d   = rp_q + PW'(pop);

        if (redirect_valid) begin
            drop_d = ost_q - OW'(rsp_ok);
            pc_d   = redirect_pc & ~32'h3;
            rpc_d  = redirect_pc & ~32'h3;
            cnt_d  = '0;
            wp_d   = '0;
            rp_d   = '0;
        end else begin
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                rpc_d = rpc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            rpc_q  <= RESET_PC;
            ost_q  <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            ost_q  <= ost_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fpc_q[wp_q]  <= rpc_q;
            fdat_q[wp_q] <= imem_rsp_data;
        end
    end

    assign imem_req_addr = pc_q;
    assign instr_valid   = (cnt_q != '0);
    assign instr_data    = instr_valid ? fdat_q[rp_q] : 32'h0;
    assign instr_pc      = instr_valid ? fpc_q[rp_q] : 32'h0;
    assign outstanding   = ost_q;

endmodule

// File: tb/tb_cilantro_ifetch.sv
// Scoreboard bench for cilantro_ifetch: a latency-programmable memory model
// feeds responses; accepted fetch PCs are queued and matched at the core port.
module tb_cilantro_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [1:0]  outstanding;

    always #5 clk = ~clk;

    cilantro_ifetch #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .outstanding(outstanding)
    );

    int checks = 0;
    int failures = 0;

    logic        d_rst = 1'b1;
    logic        d_redir = 1'b0;
    logic [31:0] d_rpc = 32'h0;
    logic        d_mrdy = 1'b1;
    logic        d_crdy = 1'b1;
    int          lat = 1;
    int          cyc = 0;
    int          mo = 0;
    int          mcount = 0;
    int          mdrop = 0;
    int          npop = 0;
    logic [31:0] mpc = RESET_PC;
    logic [31:0] exq[$];
    logic [31:0] memq[$];
    int          memt[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic        rv;
        logic        erq;
        logic        mpop;
        logic [31:0] e;
        int          due;
        rst = d_rst;
        redirect_valid = d_redir;
        redirect_pc = d_rpc;
        imem_req_ready = d_mrdy;
        instr_ready = d_crdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        if (memq.size() > 0 && memt[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memq.pop_front() | 32'h13;
            void'(memt.pop_front());
        end
        #1;
        erq = !d_rst && !d_redir && mo < 2 && mo + mcount < 4;
        check("req_valid", imem_req_valid, erq);
        if (!d_rst) begin
            check("outstanding", outstanding, mo);
            check("instr_valid", instr_valid, mcount != 0);
            if (imem_req_valid)
                check("req_addr", imem_req_addr, mpc);
        end
        acc = imem_req_valid && imem_req_ready;
        rv = imem_rsp_valid && mo != 0;
        mpop = !d_rst && !d_redir && mcount != 0 && d_crdy;
        if (!d_rst && !d_redir && instr_valid && instr_ready) begin
            if (exq.size() > 0) e = exq.pop_front();
            else e = 32'hDEAD_BEE0;
            check("instr_pc", instr_pc, e);
            check("instr_data", instr_data, e | 32'h13);
            npop++;
        end
        if (d_rst) begin
            mo = 0;
            mcount = 0;
            mdrop = 0;
            mpc = RESET_PC;
            exq.delete();
            memq.delete();
            memt.delete();
        end else if (d_redir) begin
            mdrop = mo - (rv ? 1 : 0);
            mo = mdrop;
            mcount = 0;
            mpc = d_rpc & ~32'h3;
            exq.delete();
        end else begin
            if (rv) begin
                if (mdrop > 0) mdrop--;
                else mcount++;
            end
            if (mpop) mcount--;
            mo = mo + (acc ? 1 : 0) - (rv ? 1 : 0);
            if (acc) begin
                exq.push_back(mpc);
                memq.push_back(imem_req_addr);
                due = cyc + lat;
                if (memt.size() > 0 && due <= memt[$]) due = memt[$] + 1;
                memt.push_back(due);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) d_crdy = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic redirect(logic [31:0] pc);
        d_redir = 1'b1;
        d_rpc = pc;
        tick();
        d_redir = 1'b0;
    endtask

    initial begin
        int n0;
        logic [31:0] held;
        d_rst = 1'b1;
        run(2, 0);
        d_rst = 1'b0;
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_ost", outstanding, 0);
        check("rst_addr", imem_req_addr, RESET_PC);

        lat = 1;
        d_crdy = 1'b1;
        run(10, 0);
        n0 = npop;
        run(10, 0);
        check("stream_rate", npop - n0, 10);

        d_crdy = 1'b0;
        run(10, 0);
        check("bp_req_off", imem_req_valid, 0);
        check("bp_valid", instr_valid, 1);
        d_crdy = 1'b1;
        run(10, 0);

        held = mpc;
        d_mrdy = 1'b0;
        run(5, 0);
        check("stall_addr", imem_req_addr, held);
        d_mrdy = 1'b1;
        run(6, 0);

        lat = 3;
        d_crdy = 1'b0;
        run(6, 0);
        redirect(32'h0000_0103);
        check("redir_flush", instr_valid, 0);
        check("redir_addr", imem_req_addr, 32'h0000_0100);
        d_crdy = 1'b1;
        n0 = npop;
        run(15, 0);
        check("redir_progress", (npop > n0) ? 1 : 0, 1);

        for (int k = 0; k < 8; k++) begin
            lat = 2 + (k % 2);
            run(k, 1);
            redirect(32'h0000_0200 + 32'(k) * 32'h40);
            run(10, 1);
        end

        lat = 1;
        d_crdy = 1'b1;
        redirect(32'hFFFF_FFF8);
        run(8, 0);

        lat = 3;
        d_crdy = 1'b0;
        for (int i = 0; i < 10 && mo != 2; i++) tick();
        check("pre_rst_ost", outstanding, 2);
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_data", instr_data, 0);
        check("mid_rst_pc", instr_pc, 0);
        check("mid_rst_ost", outstanding, 0);
        check("mid_rst_addr", imem_req_addr, RESET_PC);
        lat = 1;
        d_crdy = 1'b1;
        n0 = npop;
        run(12, 0);
        check("restart_progress", (npop > n0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
